// File: rtl/axi_mst_pkg.sv
// axi_mst_pkg: state encoding, AXI response/burst codes and response ranking for axi_full_mst_engine.
package axi_mst_pkg;
   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/axi_full_mst_engine.sv
// axi_full_mst_engine: single-outstanding AXI4 INCR burst master; AXI_MST_4K_CHECK_EN rejects 4 KB-crossing commands.
module axi_full_mst_engine
   import axi_mst_pkg::*;
#(
   parameter int             DW   = 128,
   parameter int             AW   = 32,
   parameter int             IDW  = 4,
   parameter logic [IDW-1:0] TXID = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [AW-1:0]     cmd_addr_i,
   input  logic [7:0]        cmd_len_i,
   input  logic              wdat_valid_i,
   output logic              wdat_ready_o,
   input  logic [DW-1:0]     wdat_data_i,
   input  logic [DW/8-1:0]   wdat_strb_i,
   output logic              rdat_valid_o,
   input  logic              rdat_ready_i,
   output logic [DW-1:0]     rdat_data_o,
   output logic              rdat_last_o,
   output logic              done_valid_o,
   output logic [1:0]        done_resp_o,
   output logic [IDW-1:0]    mem_awid_o,
   output logic [AW-1:0]     mem_awaddr_o,
   output logic [7:0]        mem_awlen_o,
   output logic [2:0]        mem_awsize_o,
   output logic [1:0]        mem_awburst_o,
   output logic              mem_awvalid_o,
   input  logic              mem_awready_i,
   output logic [DW-1:0]     mem_wdata_o,
   output logic [DW/8-1:0]   mem_wstrb_o,
   output logic              mem_wlast_o,
   output logic              mem_wvalid_o,
   input  logic              mem_wready_i,
   input  logic [IDW-1:0]    mem_bid_i,
   input  logic [1:0]        mem_bresp_i,
   input  logic              mem_bvalid_i,
   output logic              mem_bready_o,
   output logic [IDW-1:0]    mem_arid_o,
   output logic [AW-1:0]     mem_araddr_o,
   output logic [7:0]        mem_arlen_o,
   output logic [2:0]        mem_arsize_o,
   output logic [1:0]        mem_arburst_o,
   output logic              mem_arvalid_o,
   input  logic              mem_arready_i,
   input  logic [IDW-1:0]    mem_rid_i,
   input  logic [DW-1:0]     mem_rdata_i,
   input  logic [1:0]        mem_rresp_i,
   input  logic              mem_rlast_i,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o
);
   localparam logic [2:0] SIZE = 3'($clog2(DW/8));
   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    len_q, len_d, cnt_q, cnt_d;
   logic [1:0]    resp_q, resp_d;
   logic          cmd_hs, r_hs, w_hs, last_beat, r_err, b_err, reject;
   assign cmd_hs    = cmd_ready_o & cmd_valid_i;
   assign r_hs      = (state_q == S_R) & mem_rvalid_i & rdat_ready_i;
   assign w_hs      = (state_q == S_W) & wdat_valid_i & mem_wready_i;
   assign last_beat = cnt_q == len_q;
   // length mismatch in either direction and foreign IDs both count as slave errors
   assign r_err     = (mem_rlast_i != last_beat) | (mem_rid_i != TXID);
   assign b_err     = mem_bid_i != TXID;
`ifdef AXI_MST_4K_CHECK_EN
   assign reject = (17'(cmd_addr_i[11:0]) + ((17'(cmd_len_i) + 17'd1) << SIZE)) > 17'd4096;
`else
   assign reject = 1'b0;
`endif
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         resp_q  <= RESP_OKAY;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;
      unique case (state_q)
         S_IDLE: if (cmd_hs) begin
            addr_d  = cmd_addr_i;
            len_d   = cmd_len_i;
            cnt_d   = '0;
            resp_d  = reject ? RESP_SLVERR : RESP_OKAY;
            state_d = reject ? S_DONE : (cmd_write_i ? S_AW : S_AR);
         end
         S_AR: state_d = mem_arready_i ? S_R : S_AR;
         S_R: if (r_hs) begin
            cnt_d   = cnt_q + 8'd1;
            resp_d  = resp_max(resp_max(resp_q, mem_rresp_i), r_err ? RESP_SLVERR : RESP_OKAY);
            state_d = mem_rlast_i ? S_DONE : S_R;
         end
         S_AW: state_d = mem_awready_i ? S_W : S_AW;
         S_W: if (w_hs) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = last_beat ? S_B : S_W;
         end
         S_B: if (mem_bvalid_i) begin
            resp_d  = resp_max(resp_max(resp_q, mem_bresp_i), b_err ? RESP_SLVERR : RESP_OKAY);
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      cmd_ready_o   = (state_q == S_IDLE) & ~rst_i;
      mem_arvalid_o = state_q == S_AR;
      mem_awvalid_o = state_q == S_AW;
      rdat_valid_o  = (state_q == S_R) & mem_rvalid_i;
      mem_rready_o  = (state_q == S_R) & rdat_ready_i;
      mem_wvalid_o  = (state_q == S_W) & wdat_valid_i;
      wdat_ready_o  = (state_q == S_W) & mem_wready_i;
      mem_wlast_o   = (state_q == S_W) & last_beat;
      mem_bready_o  = state_q == S_B;
      done_valid_o  = state_q == S_DONE;
      done_resp_o   = (state_q == S_DONE) ? resp_q : RESP_OKAY;
   end
   assign mem_awid_o    = TXID;
   assign mem_arid_o    = TXID;
   assign mem_awaddr_o  = addr_q;
   assign mem_araddr_o  = addr_q;
   assign mem_awlen_o   = len_q;
   assign mem_arlen_o   = len_q;
   assign mem_awsize_o  = SIZE;
   assign mem_arsize_o  = SIZE;
   assign mem_awburst_o = BURST_INCR;
   assign mem_arburst_o = BURST_INCR;
   assign mem_wdata_o   = wdat_data_i;
   assign mem_wstrb_o   = wdat_strb_i;
   assign rdat_data_o   = mem_rdata_i;
   assign rdat_last_o   = mem_rlast_i;
endmodule

// File: tb/tb_axi_full_mst_engine.sv
// tb_axi_full_mst_engine: vector table, hand sequences and random commands against a bench-side AXI slave and reference memory.
module tb_axi_full_mst_engine;
   localparam int DW = 128, AW = 32, IDW = 4;
`ifdef AXI_MST_4K_CHECK_EN
   localparam logic [1:0] X4K = 2'b10;
`else
   localparam logic [1:0] X4K = 2'b00;
`endif
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   logic cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [7:0] cmd_len;
   logic wdat_valid, wdat_ready, rdat_valid, rdat_ready, rdat_last, done_valid;
   logic [DW-1:0] wdat_data, rdat_data, mem_wdata, mem_rdata;
   logic [DW/8-1:0] wdat_strb, mem_wstrb;
   logic [1:0] done_resp, mem_awburst, mem_arburst, mem_bresp, mem_rresp;
   logic [IDW-1:0] mem_awid, mem_arid, mem_bid, mem_rid;
   logic [AW-1:0] mem_awaddr, mem_araddr;
   logic [7:0] mem_awlen, mem_arlen;
   logic [2:0] mem_awsize, mem_arsize;
   logic mem_awvalid, mem_awready, mem_wlast, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
   logic mem_arvalid, mem_arready, mem_rlast, mem_rvalid, mem_rready;
   axi_full_mst_engine dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_data_i(wdat_data), .wdat_strb_i(wdat_strb),
      .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_data_o(rdat_data), .rdat_last_o(rdat_last),
      .done_valid_o(done_valid), .done_resp_o(done_resp),
      .mem_awid_o(mem_awid), .mem_awaddr_o(mem_awaddr), .mem_awlen_o(mem_awlen), .mem_awsize_o(mem_awsize),
      .mem_awburst_o(mem_awburst), .mem_awvalid_o(mem_awvalid), .mem_awready_i(mem_awready),
      .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_wlast_o(mem_wlast),
      .mem_wvalid_o(mem_wvalid), .mem_wready_i(mem_wready),
      .mem_bid_i(mem_bid), .mem_bresp_i(mem_bresp), .mem_bvalid_i(mem_bvalid), .mem_bready_o(mem_bready),
      .mem_arid_o(mem_arid), .mem_araddr_o(mem_araddr), .mem_arlen_o(mem_arlen), .mem_arsize_o(mem_arsize),
      .mem_arburst_o(mem_arburst), .mem_arvalid_o(mem_arvalid), .mem_arready_i(mem_arready),
      .mem_rid_i(mem_rid), .mem_rdata_i(mem_rdata), .mem_rresp_i(mem_rresp), .mem_rlast_i(mem_rlast),
      .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready)
   );
   typedef struct {
      string       name;
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [15:0] strb;
      bit          fixed;
      logic [1:0]  rresp, bresp;
      int          rlast_at;
      logic [3:0]  id;
      bit          toggle;
      int          stall;
      logic [1:0]  exp;
   } vec_t;
   typedef struct {logic [127:0] d; logic [15:0] s;} beat_t;
   int n_chk = 0, n_fail = 0;
   logic [127:0] slv_mem [bit [27:0]];
   logic [127:0] ref_mem [bit [27:0]];
   beat_t wq[$];
   int s_stall = 0, s_rlast_at = 0;
   logic [1:0] s_rresp = 0, s_bresp = 0;
   logic [3:0] s_id = 0;
   bit h_toggle = 0, h_rstall = 0, phase = 0;
   bit r_busy = 0, w_busy = 0, b_pend = 0, c_pend = 0, exp_av = 1, done_seen = 0;
   int r_idx = 0, w_idx = 0, step_no = 0, last_hs = -10, av_step = -10, traffic = 0, w_total = 0;
   logic c_wr = 0;
   logic [31:0] c_addr = 0;
   logic [7:0] c_len = 0;
   logic [1:0] done_got = 0;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (step %0d)", name, act, exp, step_no);
      end
   endtask
   function automatic logic [127:0] rd_ref(input bit [27:0] k);
      return ref_mem.exists(k) ? ref_mem[k] : '0;
   endfunction
   function automatic logic [127:0] rd_slv(input bit [27:0] k);
      return slv_mem.exists(k) ? slv_mem[k] : '0;
   endfunction
   function automatic bit crosses(input logic [31:0] a, input logic [7:0] l);
`ifdef AXI_MST_4K_CHECK_EN
      return int'(a[11:0]) + (int'(l) + 1) * 16 > 4096;
`else
      return 1'b0;
`endif
   endfunction
   function automatic logic [1:0] mx(input logic [1:0] a, input logic [1:0] b);
      return a > b ? a : b;
   endfunction
   // expected completion code from the command and the slave's behaviour
   function automatic logic [1:0] model_resp(input vec_t v);
      logic [1:0] r;
      if (crosses(v.addr, v.len)) return 2'b10;
      r = v.wr ? v.bresp : v.rresp;
      if (v.id != 0) r = mx(r, 2'b10);
      if (!v.wr && v.rlast_at >= 0 && v.rlast_at != int'(v.len)) r = mx(r, 2'b10);
      return r;
   endfunction
   function automatic bit rnd();
      return $urandom_range(0, 99) >= s_stall;
   endfunction
   task automatic step();
      logic [127:0] cur;
      bit [27:0] k;
      @(negedge clk);
      step_no++;
      phase = ~phase;
      mem_arready = !r_busy && rnd();
      mem_rvalid  = r_busy && rnd();
      mem_rdata   = rd_slv(c_addr[31:4] + 28'(r_idx));
      mem_rlast   = r_idx == s_rlast_at;
      mem_rresp   = s_rresp;
      mem_rid     = s_id;
      mem_awready = !w_busy && !b_pend && rnd();
      mem_wready  = w_busy && rnd();
      mem_bvalid  = b_pend && rnd();
      mem_bresp   = s_bresp;
      mem_bid     = s_id;
      cmd_valid   = c_pend;
      cmd_write   = c_wr;
      cmd_addr    = c_addr;
      cmd_len     = c_len;
      wdat_valid  = wq.size() > 0 && (!h_toggle || phase);
      wdat_data   = wq.size() > 0 ? wq[0].d : '0;
      wdat_strb   = wq.size() > 0 ? wq[0].s : '0;
      rdat_ready  = !h_rstall || ($urandom_range(0, 1) == 1);
      #1;
      if (av_step == step_no) chk("axvalid_after_cmd", c_wr ? mem_awvalid : mem_arvalid, exp_av);
      if (mem_arvalid || mem_awvalid) traffic++;
      if (cmd_valid && cmd_ready) begin
         c_pend = 0;
         av_step = step_no + 1;
         last_hs = step_no;
      end
      if (mem_arvalid && mem_arready) begin
         chk("araddr", mem_araddr, c_addr);
         chk("arlen", mem_arlen, c_len);
         chk("arsize", mem_arsize, 3'd4);
         chk("arburst", mem_arburst, 2'b01);
         chk("arid", mem_arid, 4'd0);
         r_busy = 1;
         r_idx = 0;
      end
      if (mem_rvalid && mem_rready) begin
         chk("rdat_valid", rdat_valid, 1'b1);
         chk("rdat_data", rdat_data, rd_ref(c_addr[31:4] + 28'(r_idx)));
         chk("rdat_last", rdat_last, r_idx == s_rlast_at);
         if (mem_rlast) begin
            r_busy = 0;
            last_hs = step_no;
         end
         r_idx++;
      end
      if (mem_wvalid) chk("w_after_aw", w_busy, 1'b1);
      if (mem_wvalid && mem_wready) begin
         chk("wdata", mem_wdata, wq[0].d);
         chk("wstrb", mem_wstrb, wq[0].s);
         chk("wlast", mem_wlast, w_idx == int'(c_len));
         chk("wdat_ready", wdat_ready, 1'b1);
         k = c_addr[31:4] + 28'(w_idx);
         cur = rd_slv(k);
         for (int b = 0; b < 16; b++) if (mem_wstrb[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
         slv_mem[k] = cur;
         void'(wq.pop_front());
         w_idx++;
         w_total++;
         if (mem_wlast) begin
            w_busy = 0;
            b_pend = 1;
         end
      end
      if (mem_awvalid && mem_awready) begin
         chk("awaddr", mem_awaddr, c_addr);
         chk("awlen", mem_awlen, c_len);
         chk("awsize", mem_awsize, 3'd4);
         chk("awburst", mem_awburst, 2'b01);
         chk("awid", mem_awid, 4'd0);
         w_busy = 1;
         w_idx = 0;
      end
      if (mem_bvalid && mem_bready) begin
         b_pend = 0;
         last_hs = step_no;
      end
      if (done_valid) begin
         done_seen = 1;
         done_got = done_resp;
         chk("done_timing", step_no, last_hs + 1);
      end
   endtask
   task automatic run_txn(input vec_t t);
      bit rej;
      logic [127:0] d, cur;
      logic [15:0] s;
      bit [27:0] k;
      rej = crosses(t.addr, t.len);
      s_stall = t.stall;
      s_rresp = t.rresp;
      s_bresp = t.bresp;
      s_rlast_at = t.rlast_at < 0 ? int'(t.len) : t.rlast_at;
      s_id = t.id;
      h_toggle = t.toggle;
      h_rstall = t.stall > 0;
      c_wr = t.wr;
      c_addr = t.addr;
      c_len = t.len;
      exp_av = !rej;
      if (t.wr && !rej) begin
         for (int i = 0; i <= int'(t.len); i++) begin
            d = t.fixed ? 128'h0123456789ABCDEF0123456789ABCDEF : {$urandom(), $urandom(), $urandom(), $urandom()};
            s = t.strb != 0 ? t.strb : 16'($urandom());
            wq.push_back('{d, s});
            k = t.addr[31:4] + 28'(i);
            cur = rd_ref(k);
            for (int b = 0; b < 16; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
            ref_mem[k] = cur;
         end
      end
      traffic = 0;
      done_seen = 0;
      c_pend = 1;
      for (int i = 0; i < 4000 && !done_seen; i++) step();
      chk({"done_seen_", t.name}, done_seen, 1'b1);
      if (done_seen) chk({"done_resp_", t.name}, done_got, t.exp);
      if (rej) chk({"no_traffic_", t.name}, traffic, 0);
      if (t.wr) chk({"wq_drained_", t.name}, wq.size(), 0);
      step();
      chk({"cmd_ready_after_done_", t.name}, cmd_ready, 1'b1);
   endtask
   vec_t vt[16];
   vec_t v;
   initial begin
      vt[0]  = '{"wr_len3",        1, 32'h8000_0000, 8'd3,   16'hFFFF, 0, 0, 0, -1, 0, 0, 0,  2'd0};
      vt[1]  = '{"rd_len3",        0, 32'h8000_0000, 8'd3,   16'hFFFF, 0, 0, 0, -1, 0, 0, 0,  2'd0};
      vt[2]  = '{"wr_single",      1, 32'h8000_0100, 8'd0,   16'hFFFF, 1, 0, 0, -1, 0, 0, 0,  2'd0};
      vt[3]  = '{"rd_single",      0, 32'h8000_0100, 8'd0,   16'hFFFF, 0, 0, 0, -1, 0, 0, 0,  2'd0};
      vt[4]  = '{"wr_len15_stall", 1, 32'h8000_0200, 8'd15,  16'h0000, 0, 0, 0, -1, 0, 1, 40, 2'd0};
      vt[5]  = '{"rd_len15_stall", 0, 32'h8000_0200, 8'd15,  16'hFFFF, 0, 0, 0, -1, 0, 0, 30, 2'd0};
      vt[6]  = '{"rd_early_rlast", 0, 32'h8000_0000, 8'd3,   16'hFFFF, 0, 0, 0, 2,  0, 0, 0,  2'd2};
      vt[7]  = '{"rd_late_rlast",  0, 32'h8000_0000, 8'd1,   16'hFFFF, 0, 0, 0, 2,  0, 0, 0,  2'd2};
      vt[8]  = '{"wr_decerr",      1, 32'h8000_0300, 8'd1,   16'hFFFF, 0, 0, 3, -1, 0, 0, 0,  2'd3};
      vt[9]  = '{"rd_exokay",      0, 32'h8000_0300, 8'd1,   16'hFFFF, 0, 1, 0, -1, 0, 0, 0,  2'd1};
      vt[10] = '{"rd_bad_rid",     0, 32'h8000_0000, 8'd0,   16'hFFFF, 0, 0, 0, -1, 5, 0, 0,  2'd2};
      vt[11] = '{"wr_bad_bid",     1, 32'h8000_0400, 8'd0,   16'hFFFF, 0, 0, 1, -1, 5, 0, 0,  2'd2};
      vt[12] = '{"wr_len255",      1, 32'h8001_0000, 8'd255, 16'hFFFF, 0, 0, 0, -1, 0, 0, 20, 2'd0};
      vt[13] = '{"rd_len255",      0, 32'h8001_0000, 8'd255, 16'hFFFF, 0, 0, 0, -1, 0, 0, 20, 2'd0};
      vt[14] = '{"wr_4k_cross",    1, 32'h8000_0FF0, 8'd1,   16'hFFFF, 0, 0, 0, -1, 0, 0, 0,  X4K};
      vt[15] = '{"rd_4k_cross",    0, 32'h8000_0FF0, 8'd1,   16'hFFFF, 0, 0, 0, -1, 0, 0, 0,  X4K};
      mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0; mem_rresp = 0; mem_rid = 0;
      mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0; mem_bid = 0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      wdat_valid = 0; wdat_data = 0; wdat_strb = 0; rdat_ready = 0;
      step();
      step();
      chk("reset_cmd_ready", cmd_ready, 1'b0);
      chk("reset_valids", {mem_arvalid, mem_awvalid, mem_wvalid, mem_bready, mem_rready, wdat_ready, rdat_valid, done_valid}, 8'h00);
      chk("reset_done_resp", done_resp, 2'b00);
      rst = 0;
      step();
      chk("idle_cmd_ready", cmd_ready, 1'b1);
      for (int i = 0; i < 16; i++) run_txn(vt[i]);
      // abort a write burst while its fifth beat is on the bus
      s_stall = 0; h_toggle = 0; h_rstall = 0; s_id = 0; s_bresp = 0;
      c_wr = 1; c_addr = 32'h8000_5000; c_len = 8'd7; exp_av = 1;
      for (int i = 0; i < 8; i++) wq.push_back('{{4{$urandom()}}, 16'hFFFF});
      w_total = 0;
      done_seen = 0;
      c_pend = 1;
      for (int i = 0; i < 200 && w_total < 4; i++) step();
      chk("rst_reached_beat5", w_total, 4);
      chk("w_active_pre_rst", mem_wvalid, 1'b1);
      @(negedge clk);
      rst = 1;
      #1;
      chk("rst_valids_low", {mem_arvalid, mem_awvalid, mem_wvalid, mem_bready, mem_rready, wdat_ready, rdat_valid, done_valid}, 8'h00);
      chk("rst_cmd_ready_low", cmd_ready, 1'b0);
      r_busy = 0; w_busy = 0; b_pend = 0; c_pend = 0;
      wq.delete();
      step();
      step();
      rst = 0;
      step();
      chk("cmd_ready_after_rst", cmd_ready, 1'b1);
      step();
      chk("no_done_after_rst", done_seen, 1'b0);
      for (int n = 0; n < 30; n++) begin
         v.name = "rand";
         v.wr = $urandom_range(0, 1) == 1;
         v.addr = 32'h8002_0000 + {18'($urandom_range(0, 1023)), 4'h0};
         v.len = 8'($urandom_range(0, 15));
         v.strb = $urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000;
         v.fixed = 0;
         v.rresp = 2'($urandom_range(0, 1));
         v.bresp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
         case ($urandom_range(0, 5))
            0: v.rlast_at = int'(v.len) + 1;
            1: v.rlast_at = v.len > 0 ? int'(v.len) - 1 : -1;
            default: v.rlast_at = -1;
         endcase
         v.id = $urandom_range(0, 7) == 0 ? 4'($urandom_range(1, 15)) : 4'd0;
         v.toggle = $urandom_range(0, 1) == 1;
         v.stall = $urandom_range(0, 50);
         v.exp = model_resp(v);
         run_txn(v);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_full_mst_engine.md
# axi_full_mst_engine

AXI4 full-protocol burst initiator, one transaction at a time, driving the memory-channel port of the 128-bit SRAM slave. Turns a simple command/stream interface into INCR bursts on AR/R or AW/W/B. Used by bench loaders, DMA-style preload and self-check readback, and as a standalone master against `axi_full_slv_sram`.

## Interface
- DW, 128, data width; SIZE fixed to log2(DW/8)
- AW, 32, address width
- IDW, 4, AXI ID width
- TXID, 0, constant ID driven on AWID/ARID
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  AW  start address, DW/8-aligned
- cmd_len  in  8  beats minus one (AXLEN)
- wdat_valid / wdat_ready  in/out  1  write beat stream
- wdat_data  in  DW;  wdat_strb  in  DW/8
- rdat_valid / rdat_ready  out/in  1  read beat stream
- rdat_data  out  DW;  rdat_last  out  1  final beat of burst
- done_valid  out  1  one-cycle completion pulse
- done_resp  out  2  worst response of the transaction
- MEM_AW*/W*/B*/AR*/R*  AXI4 master side: AWID/ARID IDW, AWADDR/ARADDR AW, AWLEN/ARLEN 8, AWSIZE/ARSIZE 3, AWBURST/ARBURST 2 (=2'b01), WDATA DW, WSTRB DW/8, WLAST, BID/RID IDW, BRESP/RRESP 2, RDATA DW, RLAST, all VALID/READY

## Operation
- States: IDLE, AR, R, AW, W, B, DONE.
- IDLE: cmd_ready=1. On cmd handshake latch addr/len/write, clear beat counter and resp accumulator; go AW if write else AR.
- AR: ARVALID=1 with latched fields until ARREADY, then R.
- R: rdat_valid=MEM_RVALID, MEM_RREADY=rdat_ready, rdat_data=RDATA, rdat_last=RLAST (combinational pass-through). Each R handshake: counter+1, resp_acc=max(resp_acc,RRESP). Beat with RLAST ends burst -> DONE.
- Length check: RLAST on beat index != len, or beat len without RLAST, forces resp_acc=2'b10; burst still ends only on RLAST.
- AW: AWVALID=1 until AWREADY, then W. W never starts before AW is accepted.
- W: MEM_WVALID=wdat_valid, wdat_ready=MEM_WREADY, WDATA/WSTRB pass-through, WLAST=(counter==len). Handshake on WLAST beat -> B.
- B: BREADY=1; on BVALID resp_acc=max(resp_acc,BRESP) -> DONE.
- DONE: done_valid=1, done_resp=resp_acc for one cycle -> IDLE. No backpressure on done.
- BID/RID ignored except: mismatch with TXID forces resp_acc=2'b10.
- Counter is 8 bits; len=255 gives 256 beats, no wrap before WLAST/RLAST.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in IDLE afterwards; all MEM_*VALID, MEM_*READY, wdat_ready, rdat_valid, done_valid=0; done_resp=0; state IDLE.
- AXVALID asserts the cycle after cmd handshake (registered); address/len stable while VALID.
- Data paths zero-latency combinational; throughput one beat/cycle.
- done_valid rises the cycle after final R or B handshake; next cmd_ready the cycle after that. Minimum read: 1 cmd + 1 AR + N R + 1 DONE cycles.
- reset mid-burst: immediately returns to IDLE, all VALIDs low; no completion emitted. Slave state is the bench's responsibility.

## Configuration
- AXI_MST_4K_CHECK_EN defined: command whose burst crosses a 4 KB boundary (addr[11:0] + (len+1)*DW/8 > 4096) issues no bus traffic; goes IDLE -> DONE with done_resp=2'b10.
- Undefined: no check; command issued as-is.

## Structure
- Package axi_mst_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, resp max function.
- Single module; beat counter and resp accumulator inline. No sub-module.

## Test plan
- Read, addr 0x80000000, len 3, slave returns 4 beats OKAY -> 4 rdat beats, rdat_last on 4th, done_resp 0, ARLEN 3, ARSIZE 4, ARBURST 1.
- Write, len 0, strb 0xFFFF, data 0x0123...CDEF -> single beat with WLAST=1, BRESP 0, readback matches.
- Write len 15 with wdat_valid toggled every other cycle and WREADY stalls -> 16 beats in order, WLAST only on 16th.
- Read len 3, slave asserts RLAST on beat 2 -> done_resp 2'b10 after 3rd beat.
- BRESP=2'b11 -> done_resp 2'b11; reset asserted during W beat 5 of 8 -> all VALIDs 0 next edge, cmd_ready 1 after release.
- With AXI_MST_4K_CHECK_EN: addr 0x80000FF0, len 1 -> no AWVALID, done_resp 2'b10; without macro -> burst issued.
